// File: rtl/k_transpose_buffer.sv
// Captures a full K matrix as row-major tiles and replays it as K^T (tile order and tile contents transposed).
// Latency: first output tile is valid 1 clk after the last input accept; then 1 tile/clk with no bubbles.
// Backpressure: input is refused for the whole drain; output holds data/flags stable while out_ready is low.
module k_transpose_buffer #(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 2,
    parameter int ROW_TILES  = 2,
    parameter int COL_TILES  = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] out_data,
    output logic                                  out_row_last,
    output logic                                  out_last,
    output logic                                  busy
);

    localparam int TILE_W = WIDTH * BLOCK_SIZE * BLOCK_SIZE;
    localparam int N_TILES = ROW_TILES * COL_TILES;
    localparam int CW  = (N_TILES > 1)   ? $clog2(N_TILES)   : 1;
    localparam int RCW = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;
    localparam int CCW = (COL_TILES > 1) ? $clog2(COL_TILES) : 1;

    localparam logic [CW-1:0]  LAST_ADDR = CW'(N_TILES - 1);
    localparam logic [RCW-1:0] R_LAST    = RCW'(ROW_TILES - 1);
    localparam logic [CCW-1:0] C_LAST    = CCW'(COL_TILES - 1);

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_wr_cnt;
    logic [RCW-1:0]      r_r;
    logic [CCW-1:0]      r_c;
    logic                r_out_valid;
    logic [TILE_W-1:0]   r_out_data;
    logic                r_out_row_last;
    logic                r_out_last;
    logic [TILE_W-1:0]   r_mem [N_TILES];

    logic                w_in_fire;
    logic                w_last_in;
    logic                w_out_fire;
    logic [RCW-1:0]      w_nr;
    logic [CCW-1:0]      w_nc;
    logic [CW-1:0]       w_rd_addr;
    logic [TILE_W-1:0]   w_rd_data;

    // Element (i,j) of the result is element (j,i) of the source tile.
    function automatic logic [TILE_W-1:0] f_transpose(input logic [TILE_W-1:0] t);
        logic [TILE_W-1:0] o;
        o = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            for (int j = 0; j < BLOCK_SIZE; j++) begin
                o[(i*BLOCK_SIZE+j)*WIDTH +: WIDTH] = t[(j*BLOCK_SIZE+i)*WIDTH +: WIDTH];
            end
        end
        return o;
    endfunction

    assign in_ready     = (r_state == S_FILL);
    assign w_in_fire    = in_valid && in_ready;
    assign w_last_in    = w_in_fire && (r_wr_cnt == LAST_ADDR);
    assign w_out_fire   = r_out_valid && out_ready;

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_row_last = r_out_row_last;
    assign out_last     = r_out_last;
    assign busy         = (r_state != S_FILL) || (r_wr_cnt != '0);

    // Next tile coordinates to present: (0,0) on the prefetch, else r inner / c outer.
    always_comb begin
        w_nr = '0;
        w_nc = '0;
        if (!w_last_in) begin
            if (r_r == R_LAST) begin
                w_nr = '0;
                w_nc = r_c + 1'b1;
            end else begin
                w_nr = r_r + 1'b1;
                w_nc = r_c;
            end
        end
        w_rd_addr = CW'(w_nr) * CW'(COL_TILES) + CW'(w_nc);
    end

    // Read port; the bypass only matters for a 1x1 matrix, where the prefetched tile is the one being written.
    always_comb begin
        w_rd_data = r_mem[w_rd_addr];
        if (w_in_fire && (r_wr_cnt == w_rd_addr)) begin
            w_rd_data = in_data;
        end
    end

    // Tile storage write port; contents need no reset since nothing is read before it is written.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_mem[r_wr_cnt] <= in_data;
        end
    end

    // Fill/drain controller with registered output tile and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_FILL;
            r_wr_cnt       <= '0;
            r_r            <= '0;
            r_c            <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_row_last <= 1'b0;
            r_out_last     <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_in_fire) begin
                        if (w_last_in) begin
                            r_wr_cnt       <= '0;
                            r_state        <= S_DRAIN;
                            r_r            <= '0;
                            r_c            <= '0;
                            r_out_valid    <= 1'b1;
                            r_out_data     <= f_transpose(w_rd_data);
                            r_out_row_last <= (w_nr == R_LAST);
                            r_out_last     <= (w_nr == R_LAST) && (w_nc == C_LAST);
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        if (r_out_last) begin
                            r_state        <= S_FILL;
                            r_out_valid    <= 1'b0;
                            r_r            <= '0;
                            r_c            <= '0;
                            r_out_row_last <= 1'b0;
                            r_out_last     <= 1'b0;
                        end else begin
                            r_r            <= w_nr;
                            r_c            <= w_nc;
                            r_out_data     <= f_transpose(w_rd_data);
                            r_out_row_last <= (w_nr == R_LAST);
                            r_out_last     <= (w_nr == R_LAST) && (w_nc == C_LAST);
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_k_transpose_buffer.sv
module tb_k_transpose_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_row_last;
    logic        out_last;
    logic        busy;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [63:0] s_in_data = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [63:0] s_out_data;
    logic        s_out_row_last;
    logic        s_out_last;
    logic        s_busy;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    k_transpose_buffer #(.WIDTH(16), .BLOCK_SIZE(2), .ROW_TILES(2), .COL_TILES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row_last(out_row_last), .out_last(out_last), .busy(busy)
    );

    k_transpose_buffer #(.WIDTH(16), .BLOCK_SIZE(2), .ROW_TILES(1), .COL_TILES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_row_last(s_out_row_last), .out_last(s_out_last), .busy(s_busy)
    );

    // Input frames, observed outputs, and the reference sequence.
    logic [63:0] g_in [12];
    logic [63:0] g_out[$];
    bit          g_rl[$];
    bit          g_ol[$];
    int          g_out_cyc[$];
    int          g_acc_cyc[$];
    int          g_stall_idx[$];
    logic [63:0] g_stall_dat[$];
    logic [63:0] g_exp[$];
    bit          g_exp_rl[$];
    bit          g_exp_ol[$];
    int          g_first_vld;
    int          g_stall_bad;
    int          g_timeout;
    logic        g_busy_pre;
    logic        g_busy_post;
    logic        g_rdy_after;

    function automatic logic [63:0] mk(input int e00, input int e01, input int e10, input int e11);
        return {e11[15:0], e10[15:0], e01[15:0], e00[15:0]};
    endfunction

    function automatic logic [15:0] el(input logic [63:0] t, input int i, input int j);
        return t[(i*2+j)*16 +: 16];
    endfunction

    // K^T reference: tile columns become output rows; each tile mirrored about its diagonal.
    function automatic void build_exp(input int n_frames);
        logic [63:0] t;
        g_exp.delete(); g_exp_rl.delete(); g_exp_ol.delete();
        for (int f = 0; f < n_frames; f++)
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 2; r++) begin
                    t = g_in[f*6 + r*3 + c];
                    g_exp.push_back(mk(el(t,0,0), el(t,1,0), el(t,0,1), el(t,1,1)));
                    g_exp_rl.push_back(r == 1);
                    g_exp_ol.push_back(c == 2 && r == 1);
                end
    endfunction

    function automatic void load_plan(input int base, input int offset);
        for (int k = 0; k < 6; k++)
            g_in[base+k] = mk(4*k+1+offset, 4*k+2+offset, 4*k+3+offset, 4*k+4+offset);
    endfunction

    // Drives n_in tiles and collects outputs until n_out tiles handshake (or all inputs accepted if n_out==0).
    task automatic drive(input int n_in, input int n_out, input int in_mode, input int out_mode, input int max_cyc);
        int idx = 0; int cyc = 0; int stalls = 0;
        bit tog = 0; bit toggling = 0; bit prev_stall = 0; bit done = 0;
        logic [63:0] pd = '0; logic prl = 0; logic pol = 0;
        g_out.delete(); g_rl.delete(); g_ol.delete(); g_out_cyc.delete(); g_acc_cyc.delete();
        g_stall_idx.delete(); g_stall_dat.delete();
        g_first_vld = -1; g_stall_bad = 0; g_timeout = 0;
        g_busy_pre = 1'bx; g_busy_post = 1'bx; g_rdy_after = 1'bx;
        while (!done) begin
            @(negedge clk);
            if (prev_stall && !(out_valid && out_data === pd && out_row_last === prl && out_last === pol))
                g_stall_bad++;
            if (out_valid && g_first_vld < 0) g_first_vld = cyc;
            if (g_acc_cyc.size() >= 1 && cyc == g_acc_cyc[0] + 1) g_busy_post = busy;
            if (g_acc_cyc.size() == n_in && cyc == g_acc_cyc[n_in-1] + 1) g_rdy_after = in_ready;
            case (in_mode)
                0:       in_valid = (idx < n_in);
                1:       in_valid = (idx < n_in) && (cyc % 3 == 0);
                default: in_valid = (idx < n_in) && ($urandom_range(0, 1) == 1);
            endcase
            in_data = in_valid ? g_in[idx] : {$urandom, $urandom};
            case (out_mode)
                0: out_ready = 1'b1;
                1: begin
                    if (g_out.size() == 2 && !toggling) begin
                        if (stalls < 5) begin out_ready = 1'b0; stalls++; end
                        else begin toggling = 1; tog = 1; out_ready = 1'b1; end
                    end else if (toggling) begin
                        tog = !tog; out_ready = tog;
                    end else out_ready = 1'b1;
                end
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (in_valid && in_ready) begin
                if (idx == 0) g_busy_pre = busy;
                g_acc_cyc.push_back(cyc);
                idx++;
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data; prl = out_row_last; pol = out_last;
            if (out_valid && !out_ready) begin
                g_stall_idx.push_back(g_out.size());
                g_stall_dat.push_back(out_data);
            end
            if (out_valid && out_ready) begin
                g_out.push_back(out_data); g_rl.push_back(out_row_last);
                g_ol.push_back(out_last); g_out_cyc.push_back(cyc);
            end
            cyc++;
            if ((n_out > 0) ? (g_out.size() == n_out) : (idx == n_in)) done = 1;
            else if (cyc >= max_cyc) begin g_timeout++; done = 1; end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
        end
        n_checks++;
        if (out_data !== 64'd0 || out_row_last !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: out_data=%h rl=%b last=%b, required 0 0 0", out_data, out_row_last, out_last);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream;
        load_plan(0, 0);
        build_exp(1);
        drive(6, 6, 0, 0, 200);
        n_checks++;
        if (g_timeout !== 0 || g_out.size() !== 6) begin
            n_fail++; $display("FAIL stream_count: got %0d tiles timeout=%0d, required 6", g_out.size(), g_timeout);
        end
        for (int k = 0; k < g_out.size() && k < 6; k++) begin
            n_checks++;
            if (g_out[k] !== g_exp[k] || g_rl[k] !== g_exp_rl[k] || g_ol[k] !== g_exp_ol[k] || g_out_cyc[k] !== g_acc_cyc[5] + 1 + k) begin
                n_fail++;
                $display("FAIL stream_tile%0d: data=%h rl=%b last=%b cyc=%0d, required %h %b %b %0d",
                         k, g_out[k], g_rl[k], g_ol[k], g_out_cyc[k], g_exp[k], g_exp_rl[k], g_exp_ol[k], g_acc_cyc[5]+1+k);
            end
        end
        n_checks++;
        if (g_first_vld !== g_acc_cyc[5] + 1 || g_rdy_after !== 1'b0) begin
            n_fail++; $display("FAIL stream_latency: first valid cyc=%0d in_ready=%b, required %0d 0", g_first_vld, g_rdy_after, g_acc_cyc[5]+1);
        end
        n_checks++;
        if (g_exp[0] !== mk(1,3,2,4) || g_exp[1] !== mk(13,15,14,16)) begin
            n_fail++; $display("FAIL model_anchor: %h %h, required %h %h", g_exp[0], g_exp[1], mk(1,3,2,4), mk(13,15,14,16));
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stream_after: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_backpressure;
        int n2;
        load_plan(0, 0);
        build_exp(1);
        drive(6, 6, 0, 1, 400);
        n_checks++;
        if (g_timeout !== 0 || g_out.size() !== 6 || g_stall_bad !== 0) begin
            n_fail++; $display("FAIL bp_hold: tiles=%0d timeout=%0d unstable=%0d, required 6 0 0", g_out.size(), g_timeout, g_stall_bad);
        end
        for (int k = 0; k < g_out.size() && k < 6; k++) begin
            n_checks++;
            if (g_out[k] !== g_exp[k] || g_rl[k] !== g_exp_rl[k] || g_ol[k] !== g_exp_ol[k]) begin
                n_fail++; $display("FAIL bp_tile%0d: data=%h rl=%b last=%b, required %h %b %b", k, g_out[k], g_rl[k], g_ol[k], g_exp[k], g_exp_rl[k], g_exp_ol[k]);
            end
        end
        n2 = 0;
        for (int k = 0; k < g_stall_idx.size(); k++) begin
            if (g_stall_idx[k] == 2) begin
                n2++;
                n_checks++;
                if (g_stall_dat[k] !== mk(5,7,6,8)) begin
                    n_fail++; $display("FAIL bp_stall_data: %h, required %h", g_stall_dat[k], mk(5,7,6,8));
                end
            end
        end
        n_checks++;
        if (n2 !== 5) begin
            n_fail++; $display("FAIL bp_stall_len: %0d stalled cycles on tile 2, required 5", n2);
        end
    endtask

    task automatic test_sparse;
        load_plan(0, 0);
        build_exp(1);
        drive(6, 6, 1, 0, 400);
        n_checks++;
        if (g_timeout !== 0 || g_out.size() !== 6) begin
            n_fail++; $display("FAIL sparse_count: tiles=%0d timeout=%0d, required 6 0", g_out.size(), g_timeout);
        end
        for (int k = 0; k < g_out.size() && k < 6; k++) begin
            n_checks++;
            if (g_out[k] !== g_exp[k] || g_ol[k] !== g_exp_ol[k]) begin
                n_fail++; $display("FAIL sparse_tile%0d: data=%h last=%b, required %h %b", k, g_out[k], g_ol[k], g_exp[k], g_exp_ol[k]);
            end
        end
        n_checks++;
        if (g_busy_pre !== 1'b0 || g_busy_post !== 1'b1) begin
            n_fail++; $display("FAIL sparse_busy: before=%b after=%b, required 0 1", g_busy_pre, g_busy_post);
        end
        n_checks++;
        if (g_acc_cyc[5] !== g_acc_cyc[0] + 15) begin
            n_fail++; $display("FAIL sparse_accepts: last accept cyc=%0d, required %0d", g_acc_cyc[5], g_acc_cyc[0] + 15);
        end
    endtask

    task automatic test_reset_mid;
        load_plan(0, 0);
        build_exp(1);
        drive(3, 0, 0, 0, 50);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_fill: in_ready=%b busy=%b out_valid=%b, required 1 0 0", in_ready, busy, out_valid);
        end
        @(negedge clk) rst_n = 1'b1;
        drive(6, 2, 0, 0, 100);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || out_row_last !== 1'b0 || out_last !== 1'b0 ||
            in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_drain: valid=%b data=%h rl=%b last=%b in_ready=%b busy=%b, required 0 0 0 0 1 0",
                               out_valid, out_data, out_row_last, out_last, in_ready, busy);
        end
        @(negedge clk) rst_n = 1'b1;
        drive(6, 6, 0, 0, 200);
        n_checks++;
        if (g_timeout !== 0 || g_out.size() !== 6) begin
            n_fail++; $display("FAIL rst_frame_count: tiles=%0d timeout=%0d, required 6 0", g_out.size(), g_timeout);
        end
        for (int k = 0; k < g_out.size() && k < 6; k++) begin
            n_checks++;
            if (g_out[k] !== g_exp[k] || g_rl[k] !== g_exp_rl[k] || g_ol[k] !== g_exp_ol[k]) begin
                n_fail++; $display("FAIL rst_frame_tile%0d: data=%h, required %h", k, g_out[k], g_exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        load_plan(0, 0);
        load_plan(6, 100);
        build_exp(2);
        drive(12, 12, 0, 0, 400);
        n_checks++;
        if (g_timeout !== 0 || g_out.size() !== 12) begin
            n_fail++; $display("FAIL b2b_count: tiles=%0d timeout=%0d, required 12 0", g_out.size(), g_timeout);
        end
        for (int k = 0; k < g_out.size() && k < 12; k++) begin
            n_checks++;
            if (g_out[k] !== g_exp[k] || g_rl[k] !== g_exp_rl[k] || g_ol[k] !== g_exp_ol[k]) begin
                n_fail++; $display("FAIL b2b_tile%0d: data=%h rl=%b last=%b, required %h %b %b", k, g_out[k], g_rl[k], g_ol[k], g_exp[k], g_exp_rl[k], g_exp_ol[k]);
            end
        end
        if (g_out.size() == 12) begin
            n_checks++;
            if (g_out[6] !== mk(101,103,102,104)) begin
                n_fail++; $display("FAIL b2b_first2: %h, required %h", g_out[6], mk(101,103,102,104));
            end
            n_checks++;
            if (g_acc_cyc[6] !== g_out_cyc[5] + 1 || g_out_cyc[6] !== g_acc_cyc[11] + 1) begin
                n_fail++; $display("FAIL b2b_timing: accept6=%0d out6=%0d, required %0d %0d", g_acc_cyc[6], g_out_cyc[6], g_out_cyc[5]+1, g_acc_cyc[11]+1);
            end
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 12; k++) g_in[k] = {$urandom, $urandom};
        build_exp(2);
        drive(12, 12, 2, 2, 2000);
        n_checks++;
        if (g_timeout !== 0 || g_out.size() !== 12 || g_stall_bad !== 0) begin
            n_fail++; $display("FAIL rand_count: tiles=%0d timeout=%0d unstable=%0d, required 12 0 0", g_out.size(), g_timeout, g_stall_bad);
        end
        for (int k = 0; k < g_out.size() && k < 12; k++) begin
            n_checks++;
            if (g_out[k] !== g_exp[k] || g_rl[k] !== g_exp_rl[k] || g_ol[k] !== g_exp_ol[k]) begin
                n_fail++; $display("FAIL rand_tile%0d: data=%h, required %h", k, g_out[k], g_exp[k]);
            end
        end
    endtask

    task automatic test_single_tile;
        @(negedge clk);
        s_out_ready = 1'b1;
        s_in_valid = 1'b1;
        s_in_data = mk(9, 8, 7, 6);
        n_checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: in_ready=%b out_valid=%b, required 1 0", s_in_ready, s_out_valid);
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        n_checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== mk(9,7,8,6) || s_out_row_last !== 1'b1 || s_out_last !== 1'b1 || s_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_out: valid=%b data=%h rl=%b last=%b in_ready=%b, required 1 %h 1 1 0",
                               s_out_valid, s_out_data, s_out_row_last, s_out_last, s_in_ready, mk(9,7,8,6));
        end
        @(negedge clk);
        n_checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_busy !== 1'b0) begin
            n_fail++; $display("FAIL single_done: valid=%b in_ready=%b busy=%b, required 0 1 0", s_out_valid, s_in_ready, s_busy);
        end
        s_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_single_tile();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/k_transpose_buffer.md
Name: k_transpose_buffer

Overview:
- Sits between the K linear-projection output and the Qn·KnT matmul in the self-attention head.
- Captures the full K matrix as BLOCK_SIZE×BLOCK_SIZE tiles, arriving in row-major tile order.
- Re-emits it as K^T: tile order is transposed, and the elements inside each tile are transposed.
- Gives the matmul a B-operand stream in its native row-major tile order.

Parameters:
- WIDTH, 16, element width (set to WIDTH_OUT of the projection).
- BLOCK_SIZE, 2, tile edge in elements.
- ROW_TILES, 2, K tile rows (A_OUTER_DIMENSION_Qn_KnT / BLOCK_SIZE).
- COL_TILES, 3, K tile columns (INNER_DIMENSION_Qn_KnT / BLOCK_SIZE).
- TILE_W, WIDTH*BLOCK_SIZE*BLOCK_SIZE, derived, tile bus width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input tile valid.
- in_ready  out  1  buffer accepts input tile.
- in_data  in  TILE_W  K tile. Element (i,j) is at bits [(i*BLOCK_SIZE+j)*WIDTH +: WIDTH].
- out_valid  out  1  output tile valid.
- out_ready  in  1  downstream accepts output tile.
- out_data  out  TILE_W  K^T tile, same element packing.
- out_row_last  out  1  last tile of a K^T tile row.
- out_last  out  1  last tile of the matrix.
- busy  out  1  high whenever not in FILL with zero tiles captured.

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=FILL, in_ready=1.
  - out_valid, out_row_last, out_last, busy = 0. out_data = 0.
  - All counters 0. Tile memory contents are undefined; they are never read before being written.
- Storage: ROW_TILES*COL_TILES tiles of TILE_W bits. Synchronous write, synchronous read.
- FILL:
  - in_ready=1. A tile is accepted on any edge with in_valid&&in_ready.
  - It is written to address wr_cnt, then wr_cnt increments. Input tile (r,c) has index r*COL_TILES+c.
  - On the edge accepting tile index ROW_TILES*COL_TILES-1: wr_cnt→0, state→DRAIN.
  - in_ready drops combinationally in DRAIN, so no input is accepted in the cycle after the last one.
- DRAIN:
  - in_ready=0. Output order is c outer (0..COL_TILES-1), r inner (0..ROW_TILES-1). Read address = r*COL_TILES+c.
  - out_data element (i,j) = stored element (j,i).
  - First out_valid rises exactly 1 clock after the last-input accept edge. Read is prefetched on that edge; no bubble.
  - While out_valid&&!out_ready: out_data, out_row_last and out_last hold stable.
  - On out_valid&&out_ready, the next tile is presented on the following cycle, with no bubble. Sustained throughput is 1 tile/clk.
  - out_row_last=1 when r==ROW_TILES-1. out_last=1 on the final tile (c==COL_TILES-1, r==ROW_TILES-1).
  - Handshake on the out_last tile: out_valid→0, counters→0, state→FILL. in_ready is 1 the next cycle.
- busy=1 from the first input accept until the out_last handshake completes.
- Reset asserted mid-FILL or mid-DRAIN: immediate return to the reset values. Partial data is discarded. The next input tile is treated as index 0.
- in_valid in DRAIN is ignored; upstream must hold it, since in_ready=0.
- out_ready has no effect while out_valid=0.
- ROW_TILES=COL_TILES=1 is legal: single tile, transposed, with out_row_last=out_last=1.

Test Plan:
Default parameters. Input tiles T0..T5; tile Tk = {4k+1, 4k+2, 4k+3, 4k+4} at element positions (0,0), (0,1), (1,0), (1,1).
1. Stream T0..T5 back-to-back with out_ready=1 → in_ready low after the 6th accept.
   - out_valid one clock later, then 6 consecutive output tiles in order T0, T3, T1, T4, T2, T5.
   - First output = {1,3,2,4}; second = {13,15,14,16}.
   - out_row_last on outputs 2, 4, 6; out_last only on output 6.
   - in_ready=1 the cycle after.
2. Backpressure: out_ready=0 for 5 cycles on output 3, then toggle 1/0 every cycle → out_data stays {5,7,6,8} during the stall; no tile dropped or duplicated; same final sequence as test 1.
3. Sparse input: in_valid pulsed every 3rd cycle → only valid cycles are written. Output is identical to test 1; busy rises on the first accept.
4. rst_n asserted after 3 inputs, then after 2 outputs of a second frame → all outputs return to reset values asynchronously. A fresh 6-tile frame then reproduces the test-1 output exactly.
5. Two frames back-to-back, second frame tiles offset by +100 → second-frame first output = {101,103,102,104}. No second-frame input is accepted before the first frame's out_last handshake.
6. ROW_TILES=COL_TILES=1, input {9,8,7,6} → output {9,7,8,6}, with out_row_last=out_last=1 and out_valid one clock after the accept.
